// File: rtl/cluster_event_buffer.sv
// Per-cluster event buffer. This is a FIFO that only advertises data once a
// whole event, terminated by a footer word, has been stored. The downstream
// reader therefore never waits for words in the middle of an event.
module cluster_event_buffer #(
  parameter int          DATA_WIDTH      = 65,
  parameter int          FIFO_DEPTH_BITS = 6,
  parameter int          AF_MARGIN       = 8,
  parameter logic [7:0]  FOOTER_TAG      = 8'hCD
) (
  input  logic                  cb_clk,
  input  logic                  cb_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_wren,
  output logic                  in_almost_full,
  output logic [DATA_WIDTH-1:0] cluster_data,
  input  logic                  cluster_req,
  output logic                  cluster_empty,
  output logic                  cluster_almost_full,
  output logic                  ovf_err,
  output logic                  udf_err,
  output logic                  oversize_err
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] DEPTH_V = (FIFO_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_BITS:0] AF_V    = (FIFO_DEPTH_BITS + 1)'(AF_MARGIN);

  // A footer is a metadata word that carries the end-of-event tag.
  function automatic logic is_footer(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1] && (w[DATA_WIDTH-2 -: 8] == FOOTER_TAG);
  endfunction

  logic [DATA_WIDTH-1:0]      mem_q [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   occ_q, occ_d;
  logic [FIFO_DEPTH_BITS:0]   evt_q, evt_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic                       empty_q, empty_d;
  logic                       af_q, af_d;
  logic                       ovf_q, ovf_d;
  logic                       udf_q, udf_d;
  logic                       osz_q, osz_d;

  logic                  full, wr_acc, rd_acc, wr_foot, rd_foot;
  logic [DATA_WIDTH-1:0] rd_word;

  // Next-state logic: accept/refuse, pointers, occupancy, event count, flags.
  always_comb begin
    full     = (occ_q == DEPTH_V);
    // A write while full is refused even if a read happens in the same cycle.
    wr_acc   = in_wren && !full;
    rd_acc   = cluster_req && !empty_q;
    rd_word  = mem_q[rd_ptr_q];
    wr_foot  = wr_acc && is_footer(in_data);
    rd_foot  = rd_acc && is_footer(rd_word);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    evt_d    = evt_q;
    data_d   = data_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = rd_word;
    end

    case ({wr_acc, rd_acc})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (wr_foot && !rd_foot)      evt_d = evt_q + 1'b1;
    else if (rd_foot && !wr_foot) evt_d = evt_q - 1'b1;

    empty_d = (evt_d == '0);
    af_d    = ((DEPTH_V - occ_d) <= AF_V);
    ovf_d   = ovf_q | (in_wren && full);
    udf_d   = udf_q | (cluster_req && empty_q);
    // Buffer full without a single complete event: nothing can ever drain.
    osz_d   = osz_q | ((occ_d == DEPTH_V) && (evt_d == '0));
  end

  // Storage array; contents are don't-care until written, so it has no reset.
  always_ff @(posedge cb_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= in_data;
  end

  // Control and output registers.
  always_ff @(posedge cb_clk or posedge cb_rst) begin
    if (cb_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      evt_q    <= '0;
      data_q   <= '0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      osz_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      evt_q    <= evt_d;
      data_q   <= data_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      osz_q    <= osz_d;
    end
  end

  assign in_almost_full      = af_q;
  assign cluster_almost_full = af_q;
  assign cluster_data        = data_q;
  assign cluster_empty       = empty_q;
  assign ovf_err             = ovf_q;
  assign udf_err             = udf_q;
  assign oversize_err        = osz_q;

endmodule
